// File: rtl/div_mant_iter_if.sv
// rtl/div_mant_iter_if.sv - start/operand/result bundle for div_mant_iter
// master drives the operands and start, slave returns the quotient and status.
interface div_mant_iter_if #(
  parameter int EXP_WIDTH  = 11,
  parameter int MANT_WIDTH = 52
);
  logic                  in_Start;
  logic [EXP_WIDTH-1:0]  in_ExpA;
  logic [EXP_WIDTH-1:0]  in_ExpB;
  logic [MANT_WIDTH:0]   in_MantA;
  logic [MANT_WIDTH:0]   in_MantB;
  logic [EXP_WIDTH-1:0]  out_Exp;
  logic [MANT_WIDTH:0]   out_Mant;
  logic                  out_Sticky;
  logic                  out_DivZero;
  logic                  out_Busy;
  logic                  out_Done;

  modport master (
    output in_Start, in_ExpA, in_ExpB, in_MantA, in_MantB,
    input  out_Exp, out_Mant, out_Sticky, out_DivZero, out_Busy, out_Done
  );

  modport slave (
    input  in_Start, in_ExpA, in_ExpB, in_MantA, in_MantB,
    output out_Exp, out_Mant, out_Sticky, out_DivZero, out_Busy, out_Done
  );
endinterface

// File: rtl/div_mant_iter.sv
// rtl/div_mant_iter.sv - iterative radix-2 restoring mantissa divider with exponent rebias
// Optional DIV_EARLY_EXIT_EN: finish as soon as the partial remainder becomes zero.
module div_mant_iter #(
  parameter int EXP_WIDTH  = 11,
  parameter int MANT_WIDTH = 52
) (
  input  logic clk,
  input  logic rst,
  div_mant_iter_if.slave bus
);
  localparam int MW = MANT_WIDTH + 1;
  localparam int RW = MANT_WIDTH + 2;
  localparam int CW = $clog2(MANT_WIDTH + 2);
  localparam logic [EXP_WIDTH-1:0] BIAS = {1'b0, {(EXP_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [MW-1:0]         div_q, div_d;
  logic [MW-1:0]         quo_q, quo_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [EXP_WIDTH-1:0]  exp_q, exp_d;
  logic [MW-1:0]         mant_q, mant_d;
  logic                  sticky_q, sticky_d;
  logic                  divzero_q, divzero_d;

  logic                  rem_ge;
  logic [RW-1:0]         rem_sub;
  logic [RW-1:0]         rem_nxt;
  logic [MW-1:0]         quo_nxt;
  logic [CW-1:0]         cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      mant_q    <= '0;
      sticky_q  <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      sticky_q  <= sticky_d;
      divzero_q <= divzero_d;
    end
  end

  // One restoring step: the remainder stays below 2*D, so it never outgrows RW bits.
  always_comb begin
    rem_ge  = (rem_q >= {1'b0, div_q});
    rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
    rem_nxt = rem_sub << 1;
    quo_nxt = (quo_q << 1) | MW'(rem_ge);
    cnt_nxt = cnt_q - 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    div_d     = div_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    sticky_d  = sticky_q;
    divzero_d = divzero_q;
    case (state_q)
      IDLE: begin
        if (bus.in_Start) begin
          exp_d = bus.in_ExpA - bus.in_ExpB + BIAS;
          if (bus.in_MantB == '0) begin
            mant_d    = '1;
            sticky_d  = 1'b0;
            divzero_d = 1'b1;
            state_d   = DONE;
          end else begin
            rem_d     = {1'b0, bus.in_MantA};
            div_d     = bus.in_MantB;
            quo_d     = '0;
            cnt_d     = CW'(MW);
            divzero_d = 1'b0;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_nxt;
`ifdef DIV_EARLY_EXIT_EN
        // Zero remainder means every remaining quotient bit is zero.
        if (rem_nxt == '0) begin
          quo_d    = quo_nxt << cnt_nxt;
          mant_d   = quo_nxt << cnt_nxt;
          sticky_d = 1'b0;
          state_d  = DONE;
        end else if (cnt_nxt == '0) begin
          mant_d   = quo_nxt;
          sticky_d = 1'b1;
          state_d  = DONE;
        end
`else
        if (cnt_nxt == '0) begin
          mant_d   = quo_nxt;
          sticky_d = (rem_nxt != '0);
          state_d  = DONE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out_Exp     = exp_q;
  assign bus.out_Mant    = mant_q;
  assign bus.out_Sticky  = sticky_q;
  assign bus.out_DivZero = divzero_q;
  assign bus.out_Busy    = (state_q != IDLE);
  assign bus.out_Done    = (state_q == DONE);
endmodule

// File: tb/tb_div_mant_iter.sv
// tb/tb_div_mant_iter.sv - self-checking bench for div_mant_iter
// Reference quotient/sticky come from wide integer division of MantA*2^52 by MantB.
module tb_div_mant_iter;
  localparam int EW = 11;
  localparam int MN = 52;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   lat;

  div_mant_iter_if #(.EXP_WIDTH(EW), .MANT_WIDTH(MN)) bus ();

  div_mant_iter #(.EXP_WIDTH(EW), .MANT_WIDTH(MN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [52:0] rnd_mant();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return {1'b1, r[51:0]};
  endfunction

  function automatic int exp_lat(input logic [52:0] ma, input logic [52:0] mb);
    logic [127:0] t;
    if (mb == '0) return 1;
    t = '0;
`ifdef DIV_EARLY_EXIT_EN
    for (int i = 1; i <= 53; i++) begin
      t = {75'd0, ma} << (i - 1);
      if ((t % {75'd0, mb}) == 0) return i + 1;
    end
`endif
    return 54 + int'(t[0]);
  endfunction

  task automatic check_res(input string tag, input logic [10:0] ea, input logic [10:0] eb,
                           input logic [52:0] ma, input logic [52:0] mb, input int got_lat);
    logic [127:0] num;
    logic [127:0] q;
    logic         st;
    logic [10:0]  e;
    e = ea - eb + 11'd1023;
    if (mb == '0) begin
      q  = {75'd0, {53{1'b1}}};
      st = 1'b0;
    end else begin
      num = {75'd0, ma} << 52;
      q   = num / {75'd0, mb};
      st  = ((num % {75'd0, mb}) != 0);
    end
    chk({tag, ".lat"},     got_lat,         exp_lat(ma, mb));
    chk({tag, ".mant"},    bus.out_Mant,    q[52:0]);
    chk({tag, ".exp"},     bus.out_Exp,     e);
    chk({tag, ".sticky"},  bus.out_Sticky,  st);
    chk({tag, ".divzero"}, bus.out_DivZero, (mb == '0));
    chk({tag, ".busy"},    bus.out_Busy,    1'b1);
  endtask

  task automatic scramble();
    bus.in_ExpA  = 11'($urandom());
    bus.in_ExpB  = 11'($urandom());
    bus.in_MantA = rnd_mant();
    bus.in_MantB = rnd_mant();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".exp0"},     bus.out_Exp,     11'd0);
    chk({tag, ".mant0"},    bus.out_Mant,    53'd0);
    chk({tag, ".sticky0"},  bus.out_Sticky,  1'b0);
    chk({tag, ".divzero0"}, bus.out_DivZero, 1'b0);
    chk({tag, ".busy0"},    bus.out_Busy,    1'b0);
    chk({tag, ".done0"},    bus.out_Done,    1'b0);
  endtask

  // Called #1 after the accepting edge; lat counts cycles until out_Done is seen.
  task automatic wait_done(input int inj_at, input int rst_at, output int l);
    l = 0;
    for (int n = 1; n <= 200; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      if (rst_at == n) begin
        rst = 1'b1;
        #1;
        chk_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 60; j++) begin
          @(posedge clk);
          #1;
          if (bus.out_Done !== 1'b0 || bus.out_Busy !== 1'b0) begin
            chk("abort.quiet", {bus.out_Busy, bus.out_Done}, 2'b00);
            break;
          end
        end
        l = -1;
        break;
      end
      if (bus.out_Done === 1'b1) begin
        l = n;
        break;
      end
      bus.in_Start = (inj_at == n);
    end
    bus.in_Start = 1'b0;
  endtask

  task automatic run(input logic [10:0] ea, input logic [10:0] eb, input logic [52:0] ma,
                     input logic [52:0] mb, input int inj_at, input int rst_at, output int l);
    @(negedge clk);
    bus.in_ExpA  = ea;
    bus.in_ExpB  = eb;
    bus.in_MantA = ma;
    bus.in_MantB = mb;
    bus.in_Start = 1'b1;
    @(posedge clk);
    #1;
    bus.in_Start = 1'b0;
    scramble();
    wait_done(inj_at, rst_at, l);
  endtask

  task automatic gap(input string tag, input logic [52:0] mant_hold);
    @(posedge clk);
    #1;
    chk({tag, ".pulse"}, bus.out_Done, 1'b0);
    chk({tag, ".idle"},  bus.out_Busy, 1'b0);
    chk({tag, ".hold"},  bus.out_Mant, mant_hold);
  endtask

  initial begin
    logic [10:0] ea, eb;
    logic [52:0] ma, mb;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_Start = 1'b0;
    bus.in_ExpA  = '0;
    bus.in_ExpB  = '0;
    bus.in_MantA = '0;
    bus.in_MantB = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    run(11'd1023, 11'd1023, 53'h10000000000000, 53'h10000000000000, 0, 0, lat);
    check_res("one_one", 11'd1023, 11'd1023, 53'h10000000000000, 53'h10000000000000, lat);
    gap("one_one", 53'h10000000000000);

    run(11'd1024, 11'd1023, 53'h18000000000000, 53'h10000000000000, 0, 0, lat);
    check_res("three_half", 11'd1024, 11'd1023, 53'h18000000000000, 53'h10000000000000, lat);
    chk("three_half.q", bus.out_Mant, 53'h18000000000000);
    gap("three_half", 53'h18000000000000);

    run(11'd1023, 11'd1023, 53'h10000000000000, 53'h18000000000000, 0, 0, lat);
    check_res("one_by_1p5", 11'd1023, 11'd1023, 53'h10000000000000, 53'h18000000000000, lat);
    chk("one_by_1p5.q", bus.out_Mant, 53'h0AAAAAAAAAAAAA);
    chk("one_by_1p5.lat54", lat, 54);
    gap("one_by_1p5", 53'h0AAAAAAAAAAAAA);

    ma = rnd_mant();
    run(11'd5, 11'd7, ma, 53'd0, 0, 0, lat);
    check_res("divzero", 11'd5, 11'd7, ma, 53'd0, lat);
    gap("divzero", 53'h1FFFFFFFFFFFFF);

    ma = rnd_mant();
    mb = rnd_mant();
    run(11'd2000, 11'd10, ma, mb, 0, 0, lat);
    check_res("clear_dz", 11'd2000, 11'd10, ma, mb, lat);
    gap("clear_dz", bus.out_Mant);

    ma = rnd_mant();
    mb = rnd_mant();
    run(11'd3, 11'd1500, ma, mb, 10, 0, lat);
    check_res("inject", 11'd3, 11'd1500, ma, mb, lat);

    // Start held during the out_Done cycle must wait one more cycle before acceptance.
    ea = 11'($urandom());
    eb = 11'($urandom());
    ma = rnd_mant();
    mb = rnd_mant();
    bus.in_ExpA  = ea;
    bus.in_ExpB  = eb;
    bus.in_MantA = ma;
    bus.in_MantB = mb;
    bus.in_Start = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b.pulse", bus.out_Done, 1'b0);
    chk("b2b.ignored", bus.out_Busy, 1'b0);
    @(posedge clk);
    #1;
    bus.in_Start = 1'b0;
    chk("b2b.accepted", bus.out_Busy, 1'b1);
    scramble();
    wait_done(0, 0, lat);
    check_res("b2b", ea, eb, ma, mb, lat);
    gap("b2b", bus.out_Mant);

    ma = rnd_mant();
    mb = rnd_mant();
    run(11'd900, 11'd901, ma, mb, 0, 20, lat);
    chk("abort.lat", lat, -1);

    ma = rnd_mant();
    mb = rnd_mant();
    run(11'd1023, 11'd0, ma, mb, 0, 0, lat);
    check_res("after_rst", 11'd1023, 11'd0, ma, mb, lat);
    gap("after_rst", bus.out_Mant);

    for (int i = 0; i < 8; i++) begin
      ea = 11'($urandom());
      eb = 11'($urandom());
      ma = rnd_mant();
      mb = rnd_mant();
      if (i % 3 == 0) mb = {mb[52:44], 44'd0};
      if (i % 4 == 1) ma = {ma[52:48], 48'd0};
      run(ea, eb, ma, mb, 0, 0, lat);
      check_res("rand", ea, eb, ma, mb, lat);
      gap("rand", bus.out_Mant);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
